// File: rtl/bcd_converter_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
// Default width/digit counts are also consumed by the display driver.
package bcd_converter_pkg;

    localparam int BCD_WIDTH  = 32;
    localparam int BCD_DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_converter_if.sv
// Start/done handshake and result bus between the factorial stage and the converter.
// master = requester (drives start/bin), slave = converter.
interface bcd_converter_if
    import bcd_converter_pkg::*;
#(
    parameter int WIDTH  = BCD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) ();

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  blank
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output blank
    );

endinterface

// File: rtl/bcd_converter_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Latency: done rises WIDTH edges after the accepting edge; start-to-start >= WIDTH+2.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int WIDTH  = BCD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_converter_if.slave  conv
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                state;
    logic [WIDTH-1:0]      sreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_next;
    logic [CW-1:0]         cnt;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIGITS-1:0]     blank_c;
    logic                  adj_msb_unused;

    // All digits are corrected in parallel from the pre-shift scratch.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*k +: 4]),
            .dout (adj[4*k +: 4])
        );
    end

    // Corrected digits never exceed 4'b1100, so the top bit shifted out is always zero.
    assign adj_msb_unused = adj[4*DIGITS-1];
    assign scratch_next   = {adj[4*DIGITS-2:0], sreg[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (conv.start) begin
                        sreg    <= conv.bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd_q  <= scratch_next;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Leading-zero mask: a digit blanks only if it and every higher digit are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_c    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (bcd_q[4*k +: 4] == 4'd0);
            blank_c[k] = upper_zero;
        end
        blank_c[0] = 1'b0;
    end

    assign conv.busy  = busy_q;
    assign conv.done  = done_q;
    assign conv.bcd   = bcd_q;
    assign conv.blank = blank_c;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: stimulus queues expected results, a monitor checks each done pulse.
module tb_bcd_converter;
    import bcd_converter_pkg::*;

    localparam int W = 32;
    localparam int D = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    bcd_converter_if #(.WIDTH(W), .DIGITS(D)) conv ();

    bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .conv  (conv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4*D-1:0] bcd;
        logic [D-1:0]   blank;
        int             done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && conv.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                chk("bcd", 64'(conv.bcd), 64'(mon_e.bcd));
                chk("blank", 64'(conv.blank), 64'(mon_e.blank));
            end
        end
    end

    // done is expected on the W-th edge after the accepting edge (cycle W+1 counting the accept cycle).
    task automatic launch(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic [D-1:0] ebl);
        @(negedge clk);
        conv.bin   = v;
        conv.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{eb, ebl, cyc + W});
        chk("busy_after_accept", 64'(conv.busy), 64'd1);
        @(negedge clk);
        conv.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || conv.busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 64'(n < 200), 64'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(conv.busy), 64'd0);
        chk("rst_done", 64'(conv.done), 64'd0);
        chk("rst_bcd", 64'(conv.bcd), 64'd0);
        chk("rst_blank", 64'(conv.blank), 64'b1111111110);
    endtask

    int acc;

    initial begin
        conv.start = 1'b0;
        conv.bin   = '0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Zero input.
        launch(32'd0, 40'h0000000000, 10'b1111111110);
        wait_idle();

        // 5! ; result register must hold the previous value throughout SHIFT.
        launch(32'd120, 40'h0000000120, 10'b1111111000);
        repeat (3) begin
            repeat (7) @(negedge clk);
            chk("bcd_hold_in_shift", 64'(conv.bcd), 64'd0);
            chk("busy_in_shift", 64'(conv.busy), 64'd1);
        end
        wait_idle();

        // 12! with internal zero digits, then full-scale input.
        launch(32'd479001600, 40'h0479001600, 10'b1000000000);
        wait_idle();
        launch(32'hFFFFFFFF, 40'h4294967295, 10'b0000000000);
        wait_idle();

        // Starts sampled at E5 (SHIFT) and E33 (DONE) must be ignored; bin change has no effect.
        launch(32'd5040, 40'h0000005040, 10'b1111110000);
        conv.bin = 32'd7;
        repeat (4) @(negedge clk);
        conv.start = 1'b1;
        @(negedge clk);
        conv.start = 1'b0;
        repeat (27) @(negedge clk);
        conv.start = 1'b1;
        @(negedge clk);
        conv.start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        chk("no_queued_start_busy", 64'(conv.busy), 64'd0);
        chk("no_queued_start_sb", 64'(sb.size()), 64'd0);

        // Held start re-triggers every W+2 cycles.
        @(negedge clk);
        conv.bin   = 32'd720;
        conv.start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int i = 0; i < 3; i++)
            sb.push_back('{40'h0000000720, 10'b1111111000, acc + W + i * (W + 2)});
        repeat (100) @(posedge clk);
        @(negedge clk);
        conv.start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-SHIFT discards the conversion.
        launch(32'd999, 40'h0000000999, 10'b1111111000);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_idle", 64'(conv.busy), 64'd0);

        // Fresh conversion after reset release.
        launch(32'd40320, 40'h0000040320, 10'b1111100000);
        wait_idle();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
